// File: rtl/bip_pkg.sv
// Shared constants and loader state encoding for the BIP program loader.
// LOADER_CHECKSUM_EN adds the WAIT_CK state.
package bip_pkg;
  localparam int NB_INSTRUC = 16;
  localparam int NB_OPCODE  = 5;
  localparam int NB_ADDR    = 11;

  localparam logic [NB_OPCODE-1:0] OP_HALT = '0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_HI = 3'd1,
    ST_WAIT_LO = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    ST_WAIT_CK = 3'd4,
`endif
    ST_DONE    = 3'd3
  } ldr_state_e;
endpackage

// File: rtl/bip_prog_loader.sv
// Assembles byte pairs from a UART into instruction words and writes them to program memory.
// Optional LOADER_CHECKSUM_EN: trailing XOR checksum byte after HALT, reported on o_cksum_err.
module bip_prog_loader #(
  parameter int NB_INSTRUC = bip_pkg::NB_INSTRUC,
  parameter int NB_OPCODE  = bip_pkg::NB_OPCODE,
  parameter int NB_ADDR    = bip_pkg::NB_ADDR,
  parameter int RAM_DEPTH  = 2048
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_done,
  output logic                  o_wr_en,
  output logic [NB_ADDR-1:0]    o_wr_addr,
  output logic [NB_INSTRUC-1:0] o_wr_data,
  output logic                  o_busy,
  output logic                  o_done,
`ifdef LOADER_CHECKSUM_EN
  output logic                  o_cksum_err,
`endif
  output logic                  o_overflow
);

  bip_pkg::ldr_state_e state_q;

  logic [NB_ADDR-1:0]    cnt_q;
  logic [7:0]            hi_q;
  logic                  wr_en_q, busy_q, done_q, ovf_q;
  logic [NB_ADDR-1:0]    wr_addr_q;
  logic [NB_INSTRUC-1:0] wr_data_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            xor_q;
  logic                  cksum_err_q;
`endif

  logic [NB_INSTRUC-1:0] word_d;
  logic                  halt_d, last_d;

  assign word_d = NB_INSTRUC'({hi_q, i_rx_data});
  assign halt_d = (word_d[NB_INSTRUC-1 -: NB_OPCODE] == NB_OPCODE'(bip_pkg::OP_HALT));
  assign last_d = (cnt_q == NB_ADDR'(RAM_DEPTH - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= bip_pkg::ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      xor_q       <= '0;
      cksum_err_q <= 1'b0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        bip_pkg::ST_IDLE, bip_pkg::ST_DONE: begin
          if (i_start) begin
            state_q <= bip_pkg::ST_WAIT_HI;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            xor_q       <= '0;
            cksum_err_q <= 1'b0;
`endif
          end
        end
        bip_pkg::ST_WAIT_HI: begin
          if (i_rx_done) begin
            hi_q    <= i_rx_data;
            state_q <= bip_pkg::ST_WAIT_LO;
`ifdef LOADER_CHECKSUM_EN
            xor_q   <= xor_q ^ i_rx_data;
`endif
          end
        end
        bip_pkg::ST_WAIT_LO: begin
          if (i_rx_done) begin
            wr_en_q   <= 1'b1;
            wr_data_q <= word_d;
            wr_addr_q <= cnt_q;
`ifdef LOADER_CHECKSUM_EN
            xor_q     <= xor_q ^ i_rx_data;
`endif
            // Counter parks at the last address instead of wrapping.
            if (!last_d) cnt_q <= cnt_q + 1'b1;
            if (halt_d) begin
`ifdef LOADER_CHECKSUM_EN
              state_q <= bip_pkg::ST_WAIT_CK;
`else
              state_q <= bip_pkg::ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
`endif
            end else if (last_d) begin
              state_q <= bip_pkg::ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              ovf_q   <= 1'b1;
            end else begin
              state_q <= bip_pkg::ST_WAIT_HI;
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        bip_pkg::ST_WAIT_CK: begin
          if (i_rx_done) begin
            cksum_err_q <= (i_rx_data != xor_q);
            state_q     <= bip_pkg::ST_DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end
        end
`endif
        default: begin
          state_q <= bip_pkg::ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_wr_en    = wr_en_q;
  assign o_wr_addr  = wr_addr_q;
  assign o_wr_data  = wr_data_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_overflow = ovf_q;
`ifdef LOADER_CHECKSUM_EN
  assign o_cksum_err = cksum_err_q;
`endif

endmodule

// File: tb/tb_bip_prog_loader.sv
// Directed bench for bip_prog_loader: a default-depth instance and a RAM_DEPTH=4 instance share stimulus.
module tb_bip_prog_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;

  logic        wr_en, busy, done, ovf;
  logic [10:0] wr_addr;
  logic [15:0] wr_data;
  logic        s_wr_en, s_busy, s_done, s_ovf;
  logic [10:0] s_wr_addr;
  logic [15:0] s_wr_data;
`ifdef LOADER_CHECKSUM_EN
  logic        ck_err, s_ck_err;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bip_prog_loader dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data), .o_busy(busy), .o_done(done),
`ifdef LOADER_CHECKSUM_EN
    .o_cksum_err(ck_err),
`endif
    .o_overflow(ovf)
  );

  bip_prog_loader #(.RAM_DEPTH(4)) dut_s (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .o_wr_en(s_wr_en), .o_wr_addr(s_wr_addr), .o_wr_data(s_wr_data), .o_busy(s_busy), .o_done(s_done),
`ifdef LOADER_CHECKSUM_EN
    .o_cksum_err(s_ck_err),
`endif
    .o_overflow(s_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b; rx_done = 1'b1; tick(); rx_done = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".wr_en"}, 32'(wr_en), 0);
    chk({tag, ".addr"},  32'(wr_addr), 0);
    chk({tag, ".data"},  32'(wr_data), 0);
    chk({tag, ".busy"},  32'(busy), 0);
    chk({tag, ".done"},  32'(done), 0);
    chk({tag, ".ovf"},   32'(ovf), 0);
  endtask

  initial begin
    #12; chk_all_zero("reset");
    rst = 1'b0; tick();

    // Basic two-word program ending in HALT.
    pulse_start();
    chk("t1.busy", 32'(busy), 1);
    send(8'h08); chk("t1.noWrHi", 32'(wr_en), 0);
    send(8'h1D);
    chk("t1.wr0.en", 32'(wr_en), 1); chk("t1.wr0.addr", 32'(wr_addr), 0);
    chk("t1.wr0.data", 32'(wr_data), 32'h081D);
    send(8'h00); chk("t1.pulse1", 32'(wr_en), 0);
    send(8'h00);
    chk("t1.wr1.en", 32'(wr_en), 1); chk("t1.wr1.addr", 32'(wr_addr), 1);
    chk("t1.wr1.data", 32'(wr_data), 32'h0000);
`ifdef LOADER_CHECKSUM_EN
    chk("t1.busyCk", 32'(busy), 1);
    send(8'h15);
    chk("t1.ckErr", 32'(ck_err), 0);
`endif
    chk("t1.done", 32'(done), 1); chk("t1.busy0", 32'(busy), 0); chk("t1.ovf", 32'(ovf), 0);
    send(8'h08); tick(); chk("t1.ignoreRx", 32'(wr_en), 0);

    // Overflow on the 4-deep instance; default instance keeps going.
    pulse_start();
    chk("t2.ovfCleared", 32'(s_ovf), 0); chk("t2.doneCleared", 32'(s_done), 0);
    for (int i = 0; i < 4; i++) begin
      send(8'h08); send(8'h01);
      chk($sformatf("t2.s.wr%0d.en", i), 32'(s_wr_en), 1);
      chk($sformatf("t2.s.wr%0d.addr", i), 32'(s_wr_addr), i);
      chk($sformatf("t2.s.wr%0d.data", i), 32'(s_wr_data), 32'h0801);
    end
    chk("t2.s.ovf", 32'(s_ovf), 1); chk("t2.s.done", 32'(s_done), 1); chk("t2.s.busy", 32'(s_busy), 0);
    chk("t2.big.ovf", 32'(ovf), 0); chk("t2.big.busy", 32'(busy), 1);
    send(8'h08); send(8'h01);
    chk("t2.s.noFifth", 32'(s_wr_en), 0);
    chk("t2.big.addr4", 32'(wr_addr), 4);
    tick(); chk("t2.s.ovfSticky", 32'(s_ovf), 1);

    // Reset mid-word: no partial write afterwards.
    pulse_start();
    send(8'h10);
    rst = 1'b1; #2;
    chk_all_zero("t3.asyncRst");
    tick(); rst = 1'b0; tick();
    send(8'h33); chk("t3.noWr", 32'(wr_en), 0);
    tick(); chk("t3.noWr2", 32'(wr_en), 0); chk("t3.idle", 32'(busy), 0);

    // Start during a load is ignored; addressing continues.
    pulse_start();
    send(8'h08); send(8'h01); chk("t4.wr0.addr", 32'(wr_addr), 0);
    send(8'h18);
    pulse_start();
    send(8'h05);
    chk("t4.wr.en", 32'(wr_en), 1); chk("t4.wr.addr", 32'(wr_addr), 1);
    chk("t4.wr.data", 32'(wr_data), 32'h1805);
    // High byte arriving in the write-pulse cycle.
    send(8'h08);
    chk("t5.noWr", 32'(wr_en), 0);
    send(8'h22);
    chk("t5.wr.en", 32'(wr_en), 1); chk("t5.wr.addr", 32'(wr_addr), 2);
    chk("t5.wr.data", 32'(wr_data), 32'h0822);

`ifdef LOADER_CHECKSUM_EN
    // Checksum: XOR of 08,01,00,00 is 09.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    pulse_start();
    send(8'h08); send(8'h01); send(8'h00); send(8'h00);
    chk("t6.waitCk.done", 32'(done), 0);
    send(8'h09);
    chk("t6.ckGood", 32'(ck_err), 0); chk("t6.done", 32'(done), 1);
    pulse_start();
    send(8'h08); send(8'h01); send(8'h00); send(8'h00); send(8'h0A);
    chk("t6.ckBad", 32'(ck_err), 1);
    pulse_start();
    chk("t6.ckClr", 32'(ck_err), 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/bip_prog_loader.md
BIP_PROG_LOADER -- requirements
Module: bip_prog_loader

Interface
REQ-001 SHALL have parameter NB_INSTRUC, default 16, instruction word width.
REQ-002 SHALL have parameter NB_OPCODE, default 5, opcode field width (word MSBs).
REQ-003 SHALL have parameter NB_ADDR, default 11, program memory address width.
REQ-004 SHALL have parameter RAM_DEPTH, default 2048, number of program memory words.
REQ-005 SHALL use one clock and an asynchronous, active-high reset, on the ports below.
REQ-006 SHALL have port i_clk, input, 1 bit, clock; all logic on its rising edge.
REQ-007 SHALL have port i_rst, input, 1 bit, reset.
REQ-008 SHALL have port i_start, input, 1 bit, arms a load from IDLE or DONE.
REQ-009 SHALL have port i_rx_data, input, 8 bits, received byte.
REQ-010 SHALL have port i_rx_done, input, 1 bit, one-cycle strobe qualifying i_rx_data.
REQ-011 SHALL have port o_wr_en, output, 1 bit, program memory write pulse.
REQ-012 SHALL have port o_wr_addr, output, NB_ADDR bits, write address.
REQ-013 SHALL have port o_wr_data, output, NB_INSTRUC bits, assembled instruction.
REQ-014 SHALL have port o_busy, output, 1 bit, high in WAIT_HI or WAIT_LO.
REQ-015 SHALL have port o_done, output, 1 bit, high in DONE.
REQ-016 SHALL have port o_overflow, output, 1 bit, sticky flag: memory filled without HALT.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT_HI, WAIT_LO and DONE.
REQ-018 In IDLE or DONE, i_start=1 SHALL go to WAIT_HI, clear the address counter to 0 and clear o_overflow.
REQ-019 In WAIT_HI, i_rx_done SHALL latch i_rx_data as word bits [15:8] and go to WAIT_LO.
REQ-020 In WAIT_LO, i_rx_done SHALL form the word from the latched high byte and i_rx_data as bits [7:0].
REQ-021 One cycle after that strobe, o_wr_en SHALL be 1 for exactly one cycle, with o_wr_data = word and o_wr_addr = counter.
REQ-022 After each write, the counter SHALL increment by 1.
REQ-023 A word whose opcode field (bits [15:11]) is 5'b00000 (HALT) SHALL be written and the FSM SHALL go to DONE.
REQ-024 A non-HALT word written at address RAM_DEPTH-1 SHALL set o_overflow and go to DONE; the counter SHALL not wrap.
REQ-025 A non-HALT word written below RAM_DEPTH-1 SHALL return the FSM to WAIT_HI.
REQ-026 i_start while o_busy=1 SHALL be ignored.
REQ-027 i_rx_done in IDLE or DONE SHALL be ignored, with no write.
REQ-028 A byte strobe in the same cycle as o_wr_en SHALL be accepted as the next high byte.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 i_rst=1 SHALL immediately force IDLE, counter 0, o_wr_en 0, o_wr_addr 0, o_wr_data 0, o_busy 0, o_done 0 and o_overflow 0, including during a load; no partial word SHALL be written.

Configuration
REQ-031 Macro LOADER_CHECKSUM_EN SHALL control checksum checking.
REQ-032 With LOADER_CHECKSUM_EN defined, after HALT the FSM SHALL pass through state WAIT_CK, take one byte, and compare it with the XOR of all received bytes.
REQ-033 With LOADER_CHECKSUM_EN defined, output o_cksum_err SHALL be set on a checksum mismatch, reset to 0, and cleared by i_start.
REQ-034 With LOADER_CHECKSUM_EN defined, o_busy SHALL include WAIT_CK.
REQ-035 With LOADER_CHECKSUM_EN undefined, there SHALL be no WAIT_CK state and no o_cksum_err port; HALT SHALL go directly to DONE.

Structure
REQ-036 Shared package bip_pkg SHALL hold NB_INSTRUC, NB_OPCODE, NB_ADDR, the HALT opcode constant and the loader state encoding.
REQ-037 The design SHALL be flat, with no sub-module.

Verification
REQ-038 Bytes 0x08,0x1D,0x00,0x00 -> writes 0x081D at addr 0 and 0x0000 at addr 1, then o_done=1 and o_overflow=0.
REQ-039 With RAM_DEPTH=4 and words 0x0801 x4 -> writes at addr 0..3, then o_overflow=1 and o_done=1 with no fifth write.
REQ-040 i_rst pulse after the high byte 0x10 -> IDLE with all outputs 0; a following low byte produces no write.
REQ-041 i_start mid-load after 0x18 -> ignored; the next byte 0x05 writes 0x1805 at the current address.
REQ-042 Byte strobe 0x08 in the o_wr_en cycle -> captured as the next high byte; the next word is written correctly.
REQ-043 LOADER_CHECKSUM_EN: stream 0x08,0x01,0x00,0x00 with checksum 0x09 -> o_cksum_err=0; with checksum 0x0A -> o_cksum_err=1.
